// File: rtl/tapped_grid_ram_pkg.sv
// Shared types and helpers for tapped_grid_ram.
package tapped_grid_ram_pkg;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    // Index width for n entries, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Range check done at 32 bits so a narrow index compares cleanly against any bound.
    function automatic logic idx_ok(input int unsigned idx, input int unsigned lim);
        return idx < lim;
    endfunction

endpackage

// File: rtl/tapped_grid_ram_clr_seq.sv
// Clear sweep sequencer: walks every cell once, column fastest, then drops to idle.
module tapped_grid_ram_clr_seq
    import tapped_grid_ram_pkg::*;
#(
    parameter int unsigned ROWS = 4,
    parameter int unsigned COLS = 32,
    localparam int unsigned RW = clog2_min1(ROWS),
    localparam int unsigned CW = clog2_min1(COLS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          busy,
    output logic          sweep_we,
    output logic [RW-1:0] sweep_row,
    output logic [CW-1:0] sweep_col,
    output logic          done
);

    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    state_t        state_q;
    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;
    logic          col_last;

    assign col_last  = (col_q == COL_LAST);
    assign done      = (state_q == ST_CLEAR) && col_last && (row_q == ROW_LAST);
    assign busy      = (state_q == ST_CLEAR);
    assign sweep_we  = busy;
    assign sweep_row = row_q;
    assign sweep_col = col_q;

    // Sweep FSM and cell counters; clr_req only honoured from idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clr_req) begin
                        state_q <= ST_CLEAR;
                        row_q   <= '0;
                        col_q   <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (done) begin
                        state_q <= ST_IDLE;
                        row_q   <= '0;
                        col_q   <= '0;
                    end else if (col_last) begin
                        col_q <= '0;
                        row_q <= row_q + 1'b1;
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/tapped_grid_ram.sv
// 2-D simple-dual-port RAM with registered read, row-0 tap outputs and a clear sweep.
// Optional macro RD_BYPASS_EN: same-address read/write returns the new data and taps
// forward row-0 writes in the same edge; otherwise reads are read-first.
module tapped_grid_ram
    import tapped_grid_ram_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           ROWS       = 4,
    parameter int unsigned           COLS       = 32,
    parameter int unsigned           NUM_TAPS   = 2,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VAL  = '0,
    parameter logic [7:0]            LOCK_MODE  = 8'h44,
    localparam int unsigned          RW         = clog2_min1(ROWS),
    localparam int unsigned          CW         = clog2_min1(COLS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [7:0]                     mode,
    input  logic                           clr_req,
    input  logic                           we,
    input  logic [RW-1:0]                  w_row,
    input  logic [CW-1:0]                  w_col,
    input  logic [DATA_WIDTH-1:0]          din,
    input  logic                           re,
    input  logic [RW-1:0]                  r_row,
    input  logic [CW-1:0]                  r_col,
    output logic [DATA_WIDTH-1:0]          dout,
    output logic                           rd_valid,
    output logic [NUM_TAPS*DATA_WIDTH-1:0] taps,
    output logic                           wr_err,
    output logic                           busy
);

    logic [DATA_WIDTH-1:0] mem [ROWS][COLS];

    logic                  sweep_we;
    logic [RW-1:0]         sweep_row;
    logic [CW-1:0]         sweep_col;
    logic                  sweep_done;

    logic                  wr_ok;
    logic                  rd_ok;
    logic                  rd_in_range;
    logic                  mem_we;
    logic [RW-1:0]         mem_row;
    logic [CW-1:0]         mem_col;
    logic [DATA_WIDTH-1:0] mem_wdata;

    logic [DATA_WIDTH-1:0]          dout_d, dout_q;
    logic                           rd_valid_q;
    logic [NUM_TAPS*DATA_WIDTH-1:0] taps_d, taps_q;
    logic                           wr_err_q;

    tapped_grid_ram_clr_seq #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_clr_seq (
        .clk       (clk),
        .rst       (rst),
        .clr_req   (clr_req),
        .busy      (busy),
        .sweep_we  (sweep_we),
        .sweep_row (sweep_row),
        .sweep_col (sweep_col),
        .done      (sweep_done)
    );

    assign wr_ok = we && !busy && (mode != LOCK_MODE)
                   && idx_ok(w_row, ROWS) && idx_ok(w_col, COLS);
    assign rd_ok       = re && !busy;
    assign rd_in_range = idx_ok(r_row, ROWS) && idx_ok(r_col, COLS);

    // Single memory write port: sweep wins over user traffic.
    always_comb begin
        mem_we    = 1'b0;
        mem_row   = w_row;
        mem_col   = w_col;
        mem_wdata = din;
        if (sweep_we) begin
            mem_we    = 1'b1;
            mem_row   = sweep_row;
            mem_col   = sweep_col;
            mem_wdata = CLEAR_VAL;
        end else if (wr_ok) begin
            mem_we = 1'b1;
        end
    end

    // Storage array; contents are initialised only by the sweep.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_row][mem_col] <= mem_wdata;
        end
    end

    // Read data next-state: hold unless a read is accepted.
    always_comb begin
        dout_d = dout_q;
        if (rd_ok) begin
            if (!rd_in_range) begin
                dout_d = '0;
`ifdef RD_BYPASS_EN
            end else if (wr_ok && (w_row == r_row) && (w_col == r_col)) begin
                dout_d = din;
`endif
            end else begin
                dout_d = mem[r_row][r_col];
            end
        end
    end

    // Tap next-state: row-0 cells, optionally forwarding a same-edge write.
    always_comb begin
        taps_d = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            taps_d[k*DATA_WIDTH +: DATA_WIDTH] = mem[0][k];
`ifdef RD_BYPASS_EN
            if (mem_we && (mem_row == '0) && (mem_col == CW'(k))) begin
                taps_d[k*DATA_WIDTH +: DATA_WIDTH] = mem_wdata;
            end
`endif
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q     <= '0;
            rd_valid_q <= 1'b0;
            taps_q     <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            dout_q     <= dout_d;
            rd_valid_q <= rd_ok;
            taps_q     <= taps_d;
            wr_err_q   <= we && !wr_ok;
        end
    end

    assign dout     = dout_q;
    assign rd_valid = rd_valid_q;
    assign taps     = taps_q;
    assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_tapped_grid_ram.sv
// Directed bench for tapped_grid_ram: main instance ROWS=4, second instance ROWS=3.
module tb_tapped_grid_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  mode;
    logic        clr_req;
    logic        we, re, we3, re3;
    logic [1:0]  w_row, r_row;
    logic [4:0]  w_col, r_col;
    logic [7:0]  din;
    logic [7:0]  dout, dout3;
    logic        rd_valid, rd_valid3;
    logic [15:0] taps, taps3;
    logic        wr_err, wr_err3;
    logic        busy, busy3;

    int checks = 0;
    int errors = 0;
    int cnt;
    int bad;
    logic [7:0] exp_col;
    logic [7:0] exp_tap;

    always #5 clk = ~clk;

    tapped_grid_ram #(
        .DATA_WIDTH (8),
        .ROWS       (4),
        .COLS       (32),
        .NUM_TAPS   (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .clr_req  (clr_req),
        .we       (we),
        .w_row    (w_row),
        .w_col    (w_col),
        .din      (din),
        .re       (re),
        .r_row    (r_row),
        .r_col    (r_col),
        .dout     (dout),
        .rd_valid (rd_valid),
        .taps     (taps),
        .wr_err   (wr_err),
        .busy     (busy)
    );

    tapped_grid_ram #(
        .DATA_WIDTH (8),
        .ROWS       (3),
        .COLS       (32),
        .NUM_TAPS   (2)
    ) dut3 (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .clr_req  (1'b0),
        .we       (we3),
        .w_row    (w_row),
        .w_col    (w_col),
        .din      (din),
        .re       (re3),
        .r_row    (r_row),
        .r_col    (r_col),
        .dout     (dout3),
        .rd_valid (rd_valid3),
        .taps     (taps3),
        .wr_err   (wr_err3),
        .busy     (busy3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count edges until the main instance leaves the sweep, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 400) begin
            step();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mode = 8'h00; clr_req = 1'b0;
        we = 1'b0; re = 1'b0; we3 = 1'b0; re3 = 1'b0;
        w_row = '0; w_col = '0; r_row = '0; r_col = '0; din = '0;
`ifdef RD_BYPASS_EN
        exp_col = 8'h3C;
        exp_tap = 8'h11;
`else
        exp_col = 8'h00;
        exp_tap = 8'h00;
`endif

        // Reset values
        #12;
        check("rst_busy", busy, 1);
        check("rst_dout", dout, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_taps", taps, 0);
        check("rst_wr_err", wr_err, 0);

        // Initial sweep length
        @(negedge clk);
        rst = 1'b0;
        wait_idle(cnt);
        check("sweep_len", cnt, 128);
        check("busy3_done", busy3, 0);

        // Every cell reads back as the clear value
        bad = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 32; c++) begin
                re = 1'b1; r_row = 2'(r); r_col = 5'(c);
                step();
                if (dout !== 8'h00 || rd_valid !== 1'b1) bad++;
            end
        end
        re = 1'b0;
        check("sweep_cells_bad", bad, 0);
        check("taps_cleared", taps, 0);

        // Basic write then read
        we = 1'b1; w_row = 2; w_col = 5; din = 8'hA5;
        step();
        we = 1'b0;
        check("wr_ok_no_err", wr_err, 0);
        re = 1'b1; r_row = 2; r_col = 5;
        step();
        re = 1'b0;
        check("rd_data", dout, 8'hA5);
        check("rd_valid_pulse", rd_valid, 1);
        step();
        check("rd_valid_drop", rd_valid, 0);
        check("dout_hold", dout, 8'hA5);

        // Locked write, then retry unlocked
        mode = 8'h44; we = 1'b1; w_row = 0; w_col = 0; din = 8'h11;
        step();
        we = 1'b0;
        check("lock_wr_err", wr_err, 1);
        step();
        check("lock_wr_err_clear", wr_err, 0);
        check("lock_tap0", taps[7:0], 8'h00);
        mode = 8'h00; we = 1'b1;
        step();
        we = 1'b0;
        check("unlock_no_err", wr_err, 0);
        check("tap0_edge_n", taps[7:0], exp_tap);
        step();
        check("tap0_edge_n1", taps[7:0], 8'h11);
        we = 1'b1; w_row = 0; w_col = 1; din = 8'h22;
        step();
        we = 1'b0;
        step();
        check("taps_both", taps, 16'h2211);

        // Same-address read and write
        we = 1'b1; w_row = 1; w_col = 3; din = 8'h3C;
        re = 1'b1; r_row = 1; r_col = 3;
        step();
        we = 1'b0; re = 1'b0;
        check("collision_dout", dout, exp_col);
        check("collision_valid", rd_valid, 1);
        re = 1'b1;
        step();
        re = 1'b0;
        check("collision_after", dout, 8'h3C);

        // ROWS=3 instance: out-of-range row
        we3 = 1'b1; w_row = 3; w_col = 1; din = 8'h66;
        step();
        we3 = 1'b0;
        check("r3_wr_err", wr_err3, 1);
        we3 = 1'b1; w_row = 1; w_col = 1; din = 8'h5A;
        step();
        we3 = 1'b0;
        check("r3_wr_ok", wr_err3, 0);
        re3 = 1'b1; r_row = 1; r_col = 1;
        step();
        check("r3_rd_data", dout3, 8'h5A);
        r_row = 3;
        step();
        re3 = 1'b0;
        check("r3_oob_dout", dout3, 8'h00);
        check("r3_oob_valid", rd_valid3, 1);

        // Clear request; traffic during sweep is refused
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        check("clr_busy", busy, 1);
        we = 1'b1; w_row = 2; w_col = 5; din = 8'hFF;
        re = 1'b1; r_row = 2; r_col = 5;
        step();
        we = 1'b0; re = 1'b0;
        check("busy_rd_valid", rd_valid, 0);
        check("busy_dout_hold", dout, 8'h3C);
        check("busy_wr_err", wr_err, 1);
        wait_idle(cnt);
        check("clr_sweep_len", cnt + 1, 128);
        re = 1'b1; r_row = 2; r_col = 5;
        step();
        re = 1'b0;
        check("clr_cell", dout, 8'h00);
        check("clr_taps", taps, 0);

        // Reset in the middle of a sweep
        we = 1'b1; w_row = 3; w_col = 7; din = 8'hC3;
        step();
        we = 1'b0; re = 1'b1; r_row = 3; r_col = 7;
        step();
        re = 1'b0;
        check("pre_rst_dout", dout, 8'hC3);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        we = 1'b1;
        for (int i = 0; i < 50; i++) step();
        check("mid_sweep_wr_err", wr_err, 1);
        rst = 1'b1;
        #1;
        we = 1'b0;
        check("mid_rst_busy", busy, 1);
        check("mid_rst_dout", dout, 0);
        check("mid_rst_rd_valid", rd_valid, 0);
        check("mid_rst_taps", taps, 0);
        check("mid_rst_wr_err", wr_err, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_idle(cnt);
        check("restart_sweep_len", cnt, 128);
        re = 1'b1; r_row = 3; r_col = 7;
        step();
        re = 1'b0;
        check("restart_cell", dout, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
